// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and bit-period arithmetic.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_e;

    // Rounded to the nearest whole clock count so odd ratios keep the least drift.
    function automatic int clks_per_bit(input int clk_hz, input int bit_rate);
        return (clk_hz + bit_rate / 2) / bit_rate;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Reloadable bit-period down-counter; tick_o is high while the count sits at zero.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic reload_i,
    output logic tick_o
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] RELOAD_VAL = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload on request, otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (reload_i) begin
            cnt_d = RELOAD_VAL;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/uart_tx_cnt.sv
// 8N1 UART transmitter with START/BUSY handshake; bit timing from a clock-cycle counter.
module uart_tx_cnt
    import uart_pkg::*;
#(
    parameter int BIT_RATE = 9600,
    parameter int CLK_HZ   = 12_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       busy_o
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BIT_RATE);

    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("uart_tx_cnt: CLK_HZ/BIT_RATE gives fewer than 2 clocks per bit");
    end

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       baud_reload;
    logic       baud_tick;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .reload_i(baud_reload),
        .tick_o  (baud_tick)
    );

    // Frame sequencing; the stop bit may hand straight over to a new start bit.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        baud_reload = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = START_BIT;
                    shift_d     = data_i;
                    baud_reload = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START_BIT: begin
                if (baud_tick) begin
                    state_d     = DATA_BITS;
                    idx_d       = 3'd0;
                    baud_reload = 1'b1;
                end else begin
                    state_d = START_BIT;
                end
            end
            DATA_BITS: begin
                if (baud_tick) begin
                    baud_reload = 1'b1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP_BIT;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    state_d = DATA_BITS;
                end
            end
            STOP_BIT: begin
                if (baud_tick) begin
                    baud_reload = 1'b1;
                    if (start_i) begin
                        state_d = START_BIT;
                        shift_d = data_i;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = STOP_BIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered without lag.
        case (state_d)
            IDLE:      tx_d = 1'b1;
            START_BIT: tx_d = 1'b0;
            DATA_BITS: tx_d = shift_d[0];
            STOP_BIT:  tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shift_q <= 8'h00;
            idx_q   <= 3'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_uart_tx_cnt.sv
// Bench for uart_tx_cnt: a 12-clocks/bit instance and a default-parameter instance
// compared every cycle against a frame-level reference model.
module tb_uart_tx_cnt;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st [2];
    logic [7:0] dt [2];
    logic       tx [2];
    logic       busy [2];

    int cpb [2] = '{12, 1250};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_cnt #(.BIT_RATE(1_000_000), .CLK_HZ(12_000_000)) dut_fast (
        .clk_i(clk), .rst_i(rst), .start_i(st[0]), .data_i(dt[0]),
        .tx_o(tx[0]), .busy_o(busy[0])
    );

    uart_tx_cnt dut_dflt (
        .clk_i(clk), .rst_i(rst), .start_i(st[1]), .data_i(dt[1]),
        .tx_o(tx[1]), .busy_o(busy[1])
    );

    // Reference: a frame is 10 bit-periods long counted from the accepting edge.
    logic       m_act  [2] = '{1'b0, 1'b0};
    int         m_c    [2] = '{0, 0};
    logic [7:0] m_byte [2] = '{8'h00, 8'h00};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] <= 1'b0;
                m_c[i]   <= 0;
            end else if (m_act[i] && m_c[i] < 10 * cpb[i] - 1) begin
                m_c[i] <= m_c[i] + 1;
            end else if (st[i]) begin
                m_act[i]  <= 1'b1;
                m_c[i]    <= 0;
                m_byte[i] <= dt[i];
            end else begin
                m_act[i] <= 1'b0;
            end
        end
    end

    function automatic logic exp_tx(input int i);
        logic [9:0] fr;
        fr = {1'b1, m_byte[i], 1'b0};
        if (!m_act[i]) return 1'b1;
        return fr[m_c[i] / cpb[i]];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("tx_fast",   32'(tx[0]),   32'(exp_tx(0)));
        check("busy_fast", 32'(busy[0]), 32'(m_act[0]));
        check("tx_dflt",   32'(tx[1]),   32'(exp_tx(1)));
        check("busy_dflt", 32'(busy[1]), 32'(m_act[1]));
    endtask

    // Called at the first negedge after acceptance; samples each bit mid-period.
    task automatic run_frame(input int i, input int poke_at, output logic [9:0] bits,
                             output int busy_cnt);
        bits = 10'h000;
        busy_cnt = 0;
        for (int c = 0; c < 10 * cpb[i]; c++) begin
            if (busy[i]) busy_cnt++;
            if (c % cpb[i] == cpb[i] / 2) bits[c / cpb[i]] = tx[i];
            if (c == poke_at) begin
                st[i] = 1'b1;
                dt[i] = 8'hFF;
            end else if (c == poke_at + 1) begin
                st[i] = 1'b0;
            end
            tick();
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] exp_frame;
        int         exp_busy;
    } vec_t;

    vec_t       tbl [7];
    logic [9:0] bits;
    logic [7:0] eb;
    int         bc;
    int         idle_busy;

    initial begin
        tbl[0] = '{8'h41, 10'h282, 120};
        tbl[1] = '{8'h00, 10'h200, 120};
        tbl[2] = '{8'hFF, 10'h3FE, 120};
        tbl[3] = '{8'h55, 10'h2AA, 120};
        tbl[4] = '{8'hA5, 10'h34A, 120};
        tbl[5] = '{8'h80, 10'h300, 120};
        tbl[6] = '{8'h01, 10'h202, 120};

        st[0] = 1'b0; st[1] = 1'b0; dt[0] = 8'h00; dt[1] = 8'h00;
        repeat (5) tick();
        rst = 1'b0;
        repeat (2) tick();

        for (int t = 0; t < 7; t++) begin
            st[0] = 1'b1;
            dt[0] = tbl[t].data;
            tick();
            st[0] = 1'b0;
            dt[0] = 8'($urandom);
            run_frame(0, -5, bits, bc);
            check("frame_bits", 32'(bits), 32'(tbl[t].exp_frame));
            check("busy_len", bc, tbl[t].exp_busy);
            check("busy_end", 32'(busy[0]), 32'd0);
            repeat (3) tick();
        end

        // A request during a frame must neither corrupt it nor queue another.
        st[0] = 1'b1; dt[0] = 8'h55;
        tick();
        st[0] = 1'b0;
        run_frame(0, 30, bits, bc);
        check("ignored_bits", 32'(bits), 32'h2AA);
        check("ignored_busy", bc, 120);
        idle_busy = 0;
        for (int c = 0; c < 150; c++) begin
            if (busy[0]) idle_busy++;
            tick();
        end
        check("no_queued_frame", idle_busy, 0);

        // START held high: 27 gapless frames 0x40..0x5A.
        st[0] = 1'b1; dt[0] = 8'h40;
        tick();
        for (int f = 0; f < 27; f++) begin
            if (f < 26) dt[0] = 8'h41 + 8'(f);
            else st[0] = 1'b0;
            run_frame(0, -5, bits, bc);
            eb = 8'h40 + 8'(f);
            check("b2b_bits", 32'(bits), 32'({1'b1, eb, 1'b0}));
            check("b2b_busy", bc, 120);
        end
        check("b2b_end", 32'(busy[0]), 32'd0);
        repeat (3) tick();

        st[1] = 1'b1; dt[1] = 8'h5A;
        tick();
        st[1] = 1'b0;
        run_frame(1, -5, bits, bc);
        check("dflt_bits", 32'(bits), 32'h2B4);
        check("dflt_busy", bc, 12500);
        check("dflt_end", 32'(busy[1]), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            st[0] = ($urandom_range(0, 15) == 0);
            dt[0] = 8'($urandom);
            tick();
        end
        st[0] = 1'b0;
        repeat (130) tick();

        // Asynchronous abort mid-frame, checked between clock edges.
        st[0] = 1'b1; dt[0] = 8'h3C;
        tick();
        st[0] = 1'b0;
        repeat (50) tick();
        #2 rst = 1'b1;
        #1;
        check("rst_tx", 32'(tx[0]), 32'd1);
        check("rst_busy", 32'(busy[0]), 32'd0);
        repeat (5) tick();
        rst = 1'b0;
        idle_busy = 0;
        for (int c = 0; c < 150; c++) begin
            if (busy[0]) idle_busy++;
            tick();
        end
        check("no_resume", idle_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
